bitrev_pingpong: RTL and testbench
==================================

BITREV_PINGPONG -- requirements
Module: bitrev_pingpong

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sample width in bits.
REQ-002 Parameter MAX_POINT, default 64, largest frame length; power of two, at least 2; LOG2MAX = log2(MAX_POINT).
REQ-003 Parameter LW, default $clog2(LOG2MAX+1), width of cfg_log2n.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cfg_log2n  input  LW  frame length exponent n (frame = 2^n samples); values above LOG2MAX clamp to LOG2MAX.
REQ-007 cfg_bypass  input  1  1 = natural order (no reversal) for the frame.
REQ-008 push  input  1  write one sample of data_in.
REQ-009 data_in  input  DATA_WIDTH  input sample.
REQ-010 pop  input  1  read request for one sample.
REQ-011 data_out  output  DATA_WIDTH  output sample, registered.
REQ-012 out_valid  output  1  data_out valid this cycle.
REQ-013 out_last  output  1  data_out is the final sample of its frame.
REQ-014 full  output  1  no bank writable; push ignored.
REQ-015 empty  output  1  no bank readable; pop ignored.

Function
REQ-016 Two banks of MAX_POINT x DATA_WIDTH single-port RAM with 1-cycle read latency; each bank has state FREE, WRITING, READY, READING.
REQ-017 Transitions: FREE->WRITING on first accepted push; WRITING->READY on push with write count = 2^n-1; READY->READING on first accepted pop; READING->FREE on pop with read count = 2^n-1.
REQ-018 cfg_log2n and cfg_bypass are sampled on the first push of a frame and held per bank for that frame's write and read; changes mid-frame have no effect.
REQ-019 Write address = lower n bits of write count bit-reversed (bypass: write count); read address = read count (natural order).
REQ-020 Banks are filled and drained strictly alternately via a write pointer and a read pointer, each toggling on frame completion; frame output order equals input order.
REQ-021 full = 1 when the bank at the write pointer is READY or READING; empty = 1 when the bank at the read pointer is FREE or WRITING.
REQ-022 push while full and pop while empty are ignored: no counter, state or RAM change.
REQ-023 Simultaneous push and pop are always to different banks and both proceed in the same cycle, including simultaneous write-finish and read-finish.
REQ-024 Latency: pop accepted in cycle t -> data_out, out_valid=1 in cycle t+2; out_valid, out_last, data_out always aligned.
REQ-025 out_last = 1 with the sample read at read count 2^n-1.
REQ-026 n = 0 gives 1-sample frames: each push completes a frame.
REQ-027 Sustained throughput: one push and one pop per cycle with no bubbles once a bank is READY.

Reset
REQ-028 On rst_n low, immediately: both banks FREE, pointers to bank 0, counters 0, data_out = 0, out_valid = 0, out_last = 0, full = 0, empty = 1.
REQ-029 Reset mid-frame discards all buffered data; in-flight pops produce no out_valid after reset release.
REQ-030 RAM contents are not reset.

Configuration
REQ-031 Macro BITREV_PINGPONG_ERR_EN defined: extra output err (1 bit, reset 0), sticky until reset, set one cycle after push while full or pop while empty.
REQ-032 Macro undefined: no err port, no error logic; behaviour otherwise identical.

Verification
REQ-033 MAX_POINT=16, n=3, push 0..7, then pop 8 -> out 0,4,2,6,1,5,3,7, out_last on 7, first out_valid 2 cycles after first pop.
REQ-034 n=2, bypass=1, push 10..13, pop 4 -> out 10,11,12,13, out_last on 13.
REQ-035 n=4, push 32 samples continuously with no pop -> full=1 after 32nd push, 33rd push ignored, err=1 with macro.
REQ-036 Frame A n=1 (A0,A1) then frame B n=2 (B0..B3), concurrent push/pop every cycle -> out A0,A1,B0,B2,B1,B3 in order, no bubbles.
REQ-037 rst_n low after 3 of 8 pushes, then push 0..7 with n=3, pop 8 -> output 0,4,2,6,1,5,3,7 only; empty=1 during reset.
REQ-038 pop with empty=1 after reset -> out_valid stays 0, err=1 with macro.

Source files
------------

// File: rtl/bitrev_pingpong.sv
// bitrev_pingpong
//   Ping-pong reorder buffer. There are two RAM banks. Each frame of 2^n
//   samples is written into one bank in bit-reversed address order (or in
//   natural order when bypass is set). The bank is then read back in natural
//   address order. Filling and draining alternate between the two banks, so
//   one frame can be written while the other is read.
//
//   Optional feature: when the macro BITREV_PINGPONG_ERR_EN is defined, the
//   module has an extra sticky error output `err`. It is set one cycle after
//   a push while full or a pop while empty.
//
// Parameters
//   DATA_WIDTH  sample width
//   MAX_POINT   largest frame length (a power of two, >= 2)
//   LW          width of cfg_log2n
//
// Ports
//   clk         clock; all logic uses the rising edge
//   rst_n       asynchronous active-low reset
//   cfg_log2n   frame exponent n; clamped to log2(MAX_POINT); sampled on a frame's first push
//   cfg_bypass  1 = keep natural order for the frame; sampled on a frame's first push
//   push        write data_in (ignored while full)
//   data_in     input sample
//   pop         read one sample (ignored while empty)
//   data_out    registered output sample; valid two cycles after the accepted pop
//   out_valid   data_out is valid
//   out_last    data_out is the last sample of its frame
//   full        the bank at the write pointer holds a complete frame
//   empty       the bank at the read pointer holds no complete frame
//   err         (BITREV_PINGPONG_ERR_EN only) sticky protocol-error flag
module bitrev_pingpong #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_POINT  = 64,
  parameter int LW         = $clog2($clog2(MAX_POINT) + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LW-1:0]         cfg_log2n,
  input  logic                  cfg_bypass,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  full,
  output logic                  empty
`ifdef BITREV_PINGPONG_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int AW = $clog2(MAX_POINT);

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_WRITING = 2'd1,
    ST_READY   = 2'd2,
    ST_READING = 2'd3
  } bank_state_t;

  // Per-bank state and the frame configuration latched for each bank
  bank_state_t     state_reg  [2];
  bank_state_t     state_next [2];
  logic [LW-1:0]   n_reg      [2];
  logic [LW-1:0]   n_next     [2];
  logic            bypass_reg [2];
  logic            bypass_next[2];

  logic            wr_ptr_reg, wr_ptr_next;
  logic            rd_ptr_reg, rd_ptr_next;
  logic [AW-1:0]   wr_cnt_reg, wr_cnt_next;
  logic [AW-1:0]   rd_cnt_reg, rd_cnt_next;

  // Read pipeline: stage 1 = RAM output register, stage 2 = output register
  logic            rd_v1_reg;
  logic            rd_last1_reg;
  logic            rd_bank1_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic            out_valid_reg;
  logic            out_last_reg;

  logic [1:0][DATA_WIDTH-1:0] bank_q;

  logic [LW-1:0]   cfg_n;
  logic            wr_first;
  logic [LW-1:0]   wr_n;
  logic            wr_bypass;
  logic [LW-1:0]   wr_shift;
  logic [AW-1:0]   wr_cnt_rev;
  logic [AW-1:0]   wr_addr;
  logic            wr_last;
  logic            rd_last;
  logic            push_ok;
  logic            pop_ok;

  genvar gi;

  // Mask of the low n bits. This equals the last count of a 2^n frame.
  // A shift by AW gives zero, so n = AW yields all ones.
  function automatic logic [AW-1:0] cnt_mask(input logic [LW-1:0] n);
    return ~({AW{1'b1}} << n);
  endfunction

  assign cfg_n = (cfg_log2n > LW'(AW)) ? LW'(AW) : cfg_log2n;

  assign full  = (state_reg[wr_ptr_reg] == ST_READY) || (state_reg[wr_ptr_reg] == ST_READING);
  assign empty = (state_reg[rd_ptr_reg] == ST_FREE)  || (state_reg[rd_ptr_reg] == ST_WRITING);

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // The first push of a frame uses the live configuration. Later pushes use
  // the values latched for that bank.
  assign wr_first  = (state_reg[wr_ptr_reg] == ST_FREE);
  assign wr_n      = wr_first ? cfg_n      : n_reg[wr_ptr_reg];
  assign wr_bypass = wr_first ? cfg_bypass : bypass_reg[wr_ptr_reg];

  assign wr_last = (wr_cnt_reg == cnt_mask(wr_n));
  assign rd_last = (rd_cnt_reg == cnt_mask(n_reg[rd_ptr_reg]));

  // Reverse the full AW-bit counter, then shift right by (AW - n).
  // Because count < 2^n, the result is the reversal of only the low n bits.
  for (gi = 0; gi < AW; gi++) begin : g_rev
    assign wr_cnt_rev[gi] = wr_cnt_reg[AW-1-gi];
  end

  assign wr_shift = LW'(AW) - wr_n;
  assign wr_addr  = wr_bypass ? wr_cnt_reg : (wr_cnt_rev >> wr_shift);

  // Bank state machines, pointers and counters: next-state logic.
  // A push and a pop always target different banks. Both may therefore
  // update state in the same cycle without conflict.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_next[i]  = state_reg[i];
      n_next[i]      = n_reg[i];
      bypass_next[i] = bypass_reg[i];
    end
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_cnt_next = wr_cnt_reg;
    rd_cnt_next = rd_cnt_reg;

    if (pop_ok) begin
      if (rd_last) begin
        state_next[rd_ptr_reg] = ST_FREE;
        rd_cnt_next            = '0;
        rd_ptr_next            = ~rd_ptr_reg;
      end else begin
        state_next[rd_ptr_reg] = ST_READING;
        rd_cnt_next            = rd_cnt_reg + 1'b1;
      end
    end

    if (push_ok) begin
      if (wr_first) begin
        n_next[wr_ptr_reg]      = cfg_n;
        bypass_next[wr_ptr_reg] = cfg_bypass;
      end
      // A frame with n = 0 completes on its first push, so FREE goes straight to READY.
      if (wr_last) begin
        state_next[wr_ptr_reg] = ST_READY;
        wr_cnt_next            = '0;
        wr_ptr_next            = ~wr_ptr_reg;
      end else begin
        state_next[wr_ptr_reg] = ST_WRITING;
        wr_cnt_next            = wr_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state_reg[i]  <= ST_FREE;
        n_reg[i]      <= '0;
        bypass_reg[i] <= 1'b0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_reg[i]  <= state_next[i];
        n_reg[i]      <= n_next[i];
        bypass_reg[i] <= bypass_next[i];
      end
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_cnt_reg <= wr_cnt_next;
      rd_cnt_reg <= rd_cnt_next;
    end
  end

  // Two single-port banks with a registered read. The contents are not reset.
  for (gi = 0; gi < 2; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [MAX_POINT];
    logic [DATA_WIDTH-1:0] q_reg;
    logic                  we;
    logic                  re;

    assign we = push_ok && (wr_ptr_reg == 1'(gi));
    assign re = pop_ok  && (rd_ptr_reg == 1'(gi));

    always_ff @(posedge clk) begin
      if (we) begin
        mem[wr_addr] <= data_in;
      end else if (re) begin
        q_reg <= mem[rd_cnt_reg];
      end
    end

    assign bank_q[gi] = q_reg;
  end

  // The valid and last flags travel alongside the RAM read. Resetting them
  // drops any pops still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v1_reg     <= 1'b0;
      rd_last1_reg  <= 1'b0;
      rd_bank1_reg  <= 1'b0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      rd_v1_reg     <= pop_ok;
      rd_last1_reg  <= pop_ok && rd_last;
      rd_bank1_reg  <= rd_ptr_reg;
      out_valid_reg <= rd_v1_reg;
      out_last_reg  <= rd_v1_reg && rd_last1_reg;
      if (rd_v1_reg) begin
        data_out_reg <= bank_q[rd_bank1_reg];
      end
    end
  end

  assign data_out  = data_out_reg;
  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;

`ifdef BITREV_PINGPONG_ERR_EN
  logic err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_reg <= 1'b0;
    end else if ((push && full) || (pop && empty)) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`endif

endmodule

// File: tb/tb_bitrev_pingpong.sv
// Testbench for bitrev_pingpong (MAX_POINT = 16, DATA_WIDTH = 16).
// A frame-level reference model predicts every output sample, its cycle,
// full, empty and err. A vector table and hand-written sequences add checks
// of the output order against constant expected values.
module tb_bitrev_pingpong;
  localparam int DW      = 16;
  localparam int MP      = 16;
  localparam int LW      = 3;
  localparam int LOG2MAX = 4;
  localparam int NV      = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] cfg_log2n;
  logic          cfg_bypass;
  logic          push;
  logic [DW-1:0] data_in;
  logic          pop;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          out_last;
  logic          full;
  logic          empty;
`ifdef BITREV_PINGPONG_ERR_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  bitrev_pingpong #(.DATA_WIDTH(DW), .MAX_POINT(MP), .LW(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_log2n (cfg_log2n),
    .cfg_bypass(cfg_bypass),
    .push      (push),
    .data_in   (data_in),
    .pop       (pop),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_last  (out_last),
    .full      (full),
    .empty     (empty)
`ifdef BITREV_PINGPONG_ERR_EN
    ,
    .err       (err)
`endif
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    int            cyc;
  } ent_t;

  typedef struct {
    int n;
    bit byp;
    int d0;
    int ns;
    int ex[16];
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state
  int            frame_rem[$];  // samples left to read in each complete frame, oldest first
  ent_t          exp_q[$];      // samples of complete frames, in the order they will be read
  ent_t          pend[$];       // accepted pops waiting for their output cycle
  logic [DW-1:0] cur[$];        // samples of the frame currently being written
  int            cur_n;
  bit            cur_byp;
  bit            err_m;

  ent_t          out_log[$];    // every out_valid sample seen from the DUT
  vec_t          vt[NV];
  int            pop_start;
  int            pp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rev_bits(input int k, input int n);
    int r;
    r = 0;
    for (int b = 0; b < n; b++)
      if (((k >> b) & 1) != 0) r += 1 << (n - 1 - b);
    return r;
  endfunction

  task automatic model_clear();
    frame_rem.delete();
    exp_q.delete();
    pend.delete();
    cur.delete();
    err_m = 1'b0;
  endtask

  // One clock cycle: apply the inputs, advance the model, then check the
  // outputs of the next cycle.
  task automatic step(input logic p, input logic [DW-1:0] d, input logic q);
    bit   m_full, m_empty;
    ent_t e;
    int   len;
    push = p; data_in = d; pop = q;
    m_full  = (frame_rem.size() == 2);
    m_empty = (frame_rem.size() == 0);
    if ((p && m_full) || (q && m_empty)) err_m = 1'b1;
    if (q && !m_empty) begin
      e = exp_q.pop_front();
      e.cyc = cyc + 2;
      pend.push_back(e);
      frame_rem[0] = frame_rem[0] - 1;
      if (frame_rem[0] == 0) void'(frame_rem.pop_front());
    end
    if (p && !m_full) begin
      if (cur.size() == 0) begin
        cur_n   = (int'(cfg_log2n) > LOG2MAX) ? LOG2MAX : int'(cfg_log2n);
        cur_byp = cfg_bypass;
      end
      cur.push_back(d);
      len = 1 << cur_n;
      if (cur.size() == len) begin
        for (int k = 0; k < len; k++) begin
          e.d    = cur[cur_byp ? k : rev_bits(k, cur_n)];
          e.last = (k == len - 1);
          e.cyc  = 0;
          exp_q.push_back(e);
        end
        frame_rem.push_back(len);
        cur.delete();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    push = 1'b0; pop = 1'b0;
    if (out_valid === 1'b1) begin
      e.d = data_out; e.last = out_last; e.cyc = cyc;
      out_log.push_back(e);
    end
    if (pend.size() > 0 && pend[0].cyc == cyc) begin
      e = pend.pop_front();
      $display("cyc %0d: out data=%0h last=%0b (want %0h/%0b)", cyc, data_out, out_last, e.d, e.last);
      chk("out_valid", out_valid, 1);
      chk("data_out", data_out, e.d);
      chk("out_last", out_last, e.last);
    end else begin
      chk("out_valid_idle", out_valid, 0);
    end
    chk("full", full, m_full_now());
    chk("empty", empty, frame_rem.size() == 0);
`ifdef BITREV_PINGPONG_ERR_EN
    chk("err", err, err_m);
`endif
  endtask

  function automatic bit m_full_now();
    return frame_rem.size() == 2;
  endfunction

  // Assert reset between edges. Check the immediate reset values, hold reset
  // for two edges, then release.
  task automatic do_reset();
    rst_n = 1'b0; push = 1'b0; pop = 1'b0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_data_out", data_out, 0);
    model_clear();
    repeat (2) begin
      @(posedge clk); #1; cyc++;
    end
    rst_n = 1'b1;
`ifdef BITREV_PINGPONG_ERR_EN
    chk("rst_err", err, 0);
`endif
  endtask

  task automatic flush(input int n);
    repeat (n) step(1'b0, '0, 1'b0);
  endtask

  initial begin
    // Vector table: configuration, input base value, frame length, required output order
    vt[0].n = 3; vt[0].byp = 0; vt[0].d0 = 0;  vt[0].ns = 8;
    vt[0].ex = '{0, 4, 2, 6, 1, 5, 3, 7, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1].n = 2; vt[1].byp = 1; vt[1].d0 = 10; vt[1].ns = 4;
    vt[1].ex = '{10, 11, 12, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[2].n = 1; vt[2].byp = 0; vt[2].d0 = 20; vt[2].ns = 2;
    vt[2].ex = '{20, 21, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[3].n = 0; vt[3].byp = 0; vt[3].d0 = 30; vt[3].ns = 1;
    vt[3].ex = '{30, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4].n = 7; vt[4].byp = 0; vt[4].d0 = 0;  vt[4].ns = 16;  // n clamps to 4
    vt[4].ex = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    vt[5].n = 2; vt[5].byp = 0; vt[5].d0 = 40; vt[5].ns = 4;
    vt[5].ex = '{40, 42, 41, 43, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[6].n = 3; vt[6].byp = 1; vt[6].d0 = 50; vt[6].ns = 8;
    vt[6].ex = '{50, 51, 52, 53, 54, 55, 56, 57, 0, 0, 0, 0, 0, 0, 0, 0};

    push = 1'b0; pop = 1'b0; data_in = '0; cfg_log2n = '0; cfg_bypass = 1'b0;
    do_reset();

    // Table-driven frames. The configuration is scrambled after the first push.
    for (int v = 0; v < NV; v++) begin
      out_log.delete();
      for (int i = 0; i < vt[v].ns; i++) begin
        if (i == 0) begin
          cfg_log2n = LW'(vt[v].n); cfg_bypass = vt[v].byp;
        end else begin
          cfg_log2n = LW'($urandom_range(0, 7)); cfg_bypass = ~vt[v].byp;
        end
        step(1'b1, DW'(vt[v].d0 + i), 1'b0);
      end
      pop_start = cyc;
      repeat (vt[v].ns) step(1'b0, '0, 1'b1);
      flush(3);
      chk("vec_count", out_log.size(), vt[v].ns);
      for (int i = 0; i < out_log.size() && i < vt[v].ns; i++) begin
        chk("vec_data", out_log[i].d, vt[v].ex[i]);
        chk("vec_last", out_log[i].last, i == vt[v].ns - 1);
      end
      if (out_log.size() > 0) chk("vec_latency", out_log[0].cyc - pop_start, 2);
    end

    // Pop while empty straight after reset: no output, err set
    do_reset();
    step(1'b0, '0, 1'b1);
    flush(2);
`ifdef BITREV_PINGPONG_ERR_EN
    chk("empty_pop_err", err, 1);
`endif

    // Two full n=4 frames; the 33rd push is ignored
    do_reset();
    out_log.delete();
    cfg_log2n = 3'd4; cfg_bypass = 1'b0;
    for (int i = 0; i < 32; i++) step(1'b1, DW'(100 + i), 1'b0);
    chk("full_after_32", full, 1);
    step(1'b1, 16'hBEEF, 1'b0);
`ifdef BITREV_PINGPONG_ERR_EN
    chk("full_push_err", err, 1);
`endif
    repeat (32) step(1'b0, '0, 1'b1);
    flush(3);
    chk("full_count", out_log.size(), 32);
    if (out_log.size() == 32) begin
      chk("full_d0", out_log[0].d, 100);
      chk("full_d1", out_log[1].d, 108);
      chk("full_d15", out_log[15].d, 115);
      chk("full_l15", out_log[15].last, 1);
      chk("full_d16", out_log[16].d, 116);
      chk("full_d31", out_log[31].d, 131);
    end

    // Frame A (n=1), then frame B (n=2), with a push and a pop every cycle
    do_reset();
    out_log.delete();
    cfg_log2n = 3'd1;
    step(1'b1, 16'h00A0, 1'b0);
    step(1'b1, 16'h00A1, 1'b0);
    cfg_log2n = 3'd2;
    for (int i = 0; i < 4; i++) step(1'b1, DW'(16'h00B0 + i), 1'b1);
    repeat (6) step(1'b0, '0, 1'b1);
    flush(2);
    chk("ab_count", out_log.size(), 6);
    if (out_log.size() == 6) begin
      chk("ab_0", out_log[0].d, 16'h00A0);
      chk("ab_1", out_log[1].d, 16'h00A1);
      chk("ab_2", out_log[2].d, 16'h00B0);
      chk("ab_3", out_log[3].d, 16'h00B2);
      chk("ab_4", out_log[4].d, 16'h00B1);
      chk("ab_5", out_log[5].d, 16'h00B3);
      chk("ab_a_gap", out_log[1].cyc - out_log[0].cyc, 1);
      chk("ab_b_gap", out_log[5].cyc - out_log[2].cyc, 3);
    end

    // Reset mid-frame with a pop in flight; afterwards only the new frame comes out
    do_reset();
    cfg_log2n = 3'd0;
    step(1'b1, 16'd99, 1'b0);
    cfg_log2n = 3'd3;
    for (int i = 0; i < 3; i++) step(1'b1, DW'(200 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    do_reset();
    out_log.delete();
    flush(3);
    cfg_log2n = 3'd3; cfg_bypass = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, DW'(i), 1'b0);
    repeat (8) step(1'b0, '0, 1'b1);
    flush(3);
    chk("rst_mid_count", out_log.size(), 8);
    if (out_log.size() == 8) begin
      chk("rst_mid_0", out_log[0].d, 0);
      chk("rst_mid_1", out_log[1].d, 4);
      chk("rst_mid_3", out_log[3].d, 6);
      chk("rst_mid_7", out_log[7].d, 7);
      chk("rst_mid_l7", out_log[7].last, 1);
    end

    // Random traffic: a push-heavy phase, then a pop-heavy phase
    do_reset();
    for (int i = 0; i < 600; i++) begin
      pp = (i < 300) ? 80 : 35;
      cfg_log2n  = LW'($urandom_range(0, 6));
      cfg_bypass = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 99) < pp), DW'($urandom), 1'($urandom_range(0, 99) < (115 - pp)));
    end
    repeat (40) step(1'b0, '0, 1'b1);
    flush(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
